// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode handshake bundle for the IF/ID queue.
//   master : fetch + decode side (drives pc_i, inst_i, in_valid, out_ready,
//            jump_flag, stall_signal; observes in_ready, pc_o, inst_o,
//            out_valid, count_o)
//   slave  : the queue itself (opposite directions)
interface if_id_queue_if #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STALL_LEN = 6
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]      pc_i;
  logic [XLEN-1:0]      inst_i;
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      pc_o;
  logic [XLEN-1:0]      inst_o;
  logic                 out_valid;
  logic                 out_ready;
  logic                 jump_flag;
  logic [STALL_LEN-1:0] stall_signal;
  logic [CntW-1:0]      count_o;

  modport master (
    output pc_i, inst_i, in_valid, out_ready, jump_flag, stall_signal,
    input  in_ready, pc_o, inst_o, out_valid, count_o
  );

  modport slave (
    input  pc_i, inst_i, in_valid, out_ready, jump_flag, stall_signal,
    output in_ready, pc_o, inst_o, out_valid, count_o
  );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: circular buffer of {pc, inst} entries between fetch and decode.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears pointers and occupancy
//   bus  : if_id_queue_if.slave -- push side (pc_i/inst_i/in_valid/in_ready),
//          pop side (pc_o/inst_o/out_valid/out_ready), jump_flag flush,
//          stall_signal vector, count_o occupancy
module if_id_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STALL_LEN = 6,
  parameter int unsigned STALL_BIT = 1
) (
  input logic            clk,
  input logic            rst,
  if_id_queue_if.slave   bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [PtrW-1:0] r_rptr, r_wptr;
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] w_rptr_d, w_wptr_d;
  logic [CntW-1:0] w_count_d;

  logic w_full, w_out_valid, w_in_ready, w_push, w_pop;

  // in_ready depends only on registered occupancy and jump_flag, so a pop
  // in the same cycle never frees a slot combinationally.
  assign w_full      = (r_count == CntW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_in_ready  = ~w_full & ~bus.jump_flag;
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready & ~bus.stall_signal[STALL_BIT] &
                       ~bus.jump_flag;

  always_comb begin
    w_rptr_d  = r_rptr;
    w_wptr_d  = r_wptr;
    w_count_d = r_count;
    if (bus.jump_flag) begin
      w_rptr_d  = '0;
      w_wptr_d  = '0;
      w_count_d = '0;
    end else begin
      if (w_push) w_wptr_d = r_wptr + 1'b1;  // power-of-two depth wraps naturally
      if (w_pop)  w_rptr_d = r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + 1'b1;
        2'b01:   w_count_d = r_count - 1'b1;
        default: w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= w_rptr_d;
      r_wptr  <= w_wptr_d;
      r_count <= w_count_d;
    end
  end

  // Storage is never cleared; stale entries are hidden by occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= bus.pc_i;
      r_inst_mem[r_wptr] <= bus.inst_i;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.count_o   = r_count;
  assign bus.pc_o      = w_out_valid ? r_pc_mem[r_rptr]   : '0;
  assign bus.inst_o    = w_out_valid ? r_inst_mem[r_rptr] : '0;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed-vector bench for if_id_queue (DEPTH=4, XLEN=32).
module tb_if_id_queue;
  localparam logic [31:0] InstKey = 32'hDEAD_0000;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   miscompares;
  logic [31:0] model_q[$];

  if_id_queue_if #(.DEPTH(4), .XLEN(32), .STALL_LEN(6)) bus ();

  if_id_queue #(
    .DEPTH(4), .XLEN(32), .STALL_LEN(6), .STALL_BIT(1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for the current cycle, then let combinational outputs settle.
  task automatic drive(input logic vld, input logic [31:0] pc, input logic ordy,
                       input logic jmp, input logic [5:0] stall);
    bus.in_valid     = vld;
    bus.pc_i         = pc;
    bus.inst_i       = pc ^ InstKey;
    bus.out_ready    = ordy;
    bus.jump_flag    = jmp;
    bus.stall_signal = stall;
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
    check({tag, "_cnt"}, 64'(bus.count_o), 64'(cnt));
    check({tag, "_pc"}, 64'(bus.pc_o), 64'(pc));
    check({tag, "_inst"}, 64'(bus.inst_o), (cnt == 0) ? 64'h0 : 64'(pc ^ InstKey));
  endtask

  initial begin
    vec_cnt     = 0;
    miscompares = 0;
    rst         = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'b0);
    #2;
    check("rst_cnt", 64'(bus.count_o), 64'd0);
    check("rst_vld", 64'(bus.out_valid), 64'd0);
    check("rst_pc", 64'(bus.pc_o), 64'd0);
    check("rst_inst", 64'(bus.inst_o), 64'd0);
    #5 rst = 1'b1;
    tick();
    check("rdy_after_rst", 64'(bus.in_ready), 64'd1);

    // Three pushes, no pops; head appears one cycle after the first push.
    drive(1'b1, 32'h100, 1'b0, 1'b0, 6'b0);
    check("no_bypass", 64'(bus.out_valid), 64'd0);
    tick();
    check("vld_lat1", 64'(bus.out_valid), 64'd1);
    check_head("push1", 32'h100, 3'd1);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 6'b0);
    tick();
    drive(1'b1, 32'h108, 1'b0, 1'b0, 6'b0);
    tick();
    check_head("push3", 32'h100, 3'd3);

    // Fill to DEPTH, fifth offer ignored, pop reopens in_ready next cycle.
    drive(1'b1, 32'h10C, 1'b0, 1'b0, 6'b0);
    tick();
    drive(1'b1, 32'h110, 1'b0, 1'b0, 6'b0);
    check_head("full", 32'h100, 3'd4);
    check("full_rdy", 64'(bus.in_ready), 64'd0);
    tick();
    check_head("full_ign", 32'h100, 3'd4);
    drive(1'b1, 32'h110, 1'b1, 1'b0, 6'b0);
    check("full_pop_rdy", 64'(bus.in_ready), 64'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 6'b0);
    check("rdy_reopen", 64'(bus.in_ready), 64'd1);
    check_head("pop1", 32'h104, 3'd3);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'b0);
    check_head("pop2", 32'h108, 3'd2);

    // 20 cycles of simultaneous push+pop at count 2; pointers wrap.
    model_q = '{32'h108, 32'h10C};
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0, 6'b0);
      check("stream_cnt", 64'(bus.count_o), 64'd2);
      check("stream_pc", 64'(bus.pc_o), 64'(model_q[0]));
      tick();
      model_q.push_back(32'h200 + 32'(4 * i));
      void'(model_q.pop_front());
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'b0);
    check_head("stream_end", 32'h248, 3'd2);

    // Stall bit 1 freezes the head while pushes fill the queue.
    drive(1'b1, 32'h300, 1'b1, 1'b0, 6'b000010);
    check("stall_rdy", 64'(bus.in_ready), 64'd1);
    tick();
    drive(1'b1, 32'h304, 1'b1, 1'b0, 6'b000010);
    check_head("stall3", 32'h248, 3'd3);
    tick();
    drive(1'b1, 32'h308, 1'b1, 1'b0, 6'b000010);
    check_head("stall4", 32'h248, 3'd4);
    check("stall_full_rdy", 64'(bus.in_ready), 64'd0);
    tick();
    // Only bit 1 stalls; other bits must not block the pop.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 6'b111101);
    check_head("stall_held", 32'h248, 3'd4);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'b0);
    check_head("unstall_pop", 32'h24C, 3'd3);

    // Flush with a concurrent offer: everything discarded.
    drive(1'b1, 32'h400, 1'b1, 1'b1, 6'b0);
    check("jmp_rdy", 64'(bus.in_ready), 64'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'b0);
    check("jmp_vld", 64'(bus.out_valid), 64'd0);
    check_head("jmp", 32'h0, 3'd0);
    tick();
    check_head("jmp_discard", 32'h0, 3'd0);
    drive(1'b1, 32'h500, 1'b0, 1'b0, 6'b0);
    tick();
    check_head("post_jmp", 32'h500, 3'd1);
    drive(1'b1, 32'h504, 1'b0, 1'b0, 6'b0);
    tick();
    drive(1'b1, 32'h508, 1'b0, 1'b0, 6'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'b0);
    check_head("pre_rst", 32'h500, 3'd3);

    // Asynchronous reset between edges.
    #2 rst = 1'b0;
    #1;
    check("arst_vld", 64'(bus.out_valid), 64'd0);
    check_head("arst", 32'h0, 3'd0);
    #2 rst = 1'b1;
    tick();
    check("arst_rel_vld", 64'(bus.out_valid), 64'd0);
    check("arst_rel_rdy", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 32'h600, 1'b0, 1'b0, 6'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'b0);
    check_head("arst_push", 32'h600, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule
